regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the multicycle datapath; successor to the fixed 32x32 2R1W file.
//  Provides NRD synchronous read ports, one write port, optional write-to-read bypass and optional hardwired-zero entry 0.
//  Adds a hardware clear sequencer that zeroes the whole array without a reset (used on context switch / trap entry).
// PARAMETERS
//  DW       32  data width in bits
//  AW       5   address width; DEPTH = 2**AW entries
//  NRD      2   number of read ports (1..4)
//  ZERO_R0  1   1: entry 0 always reads 0 and writes to it are discarded
//  BYPASS   1   1: same-cycle write data forwarded to matching read port
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        asynchronous, active-high reset
//  ra         in   NRD*AW   read addresses, port i at [i*AW +: AW]
//  re         in   NRD      read enables, one per port
//  rd         out  NRD*DW   registered read data, port i at [i*DW +: DW]
//  wa         in   AW       write address
//  wd         in   DW       write data
//  we         in   1        write enable
//  clr_req    in   1        request full-array clear (sampled in IDLE only)
//  clr_busy   out  1        high while clear sweep in progress
//  clr_done   out  1        one-cycle pulse after last entry cleared
//  wr_drop    out  1        one-cycle pulse: a write was discarded (we high during sweep)
// BEHAVIOUR
//  Reset: all DEPTH entries <= 0, rd <= 0, FSM <= IDLE, clr_busy/clr_done/wr_drop <= 0, sweep index <= 0.
//  Write: on rising edge with we=1 and FSM=IDLE, mem[wa] <= wd; if ZERO_R0 and wa==0, write discarded (no wr_drop).
//  Read: latency 1. On rising edge, for each port i with re[i]=1, rd_i <= value; re[i]=0 holds rd_i.
//   value = 0 if ZERO_R0 and ra_i==0;
//   else wd if BYPASS and we and FSM=IDLE and wa==ra_i;
//   else mem[ra_i] (pre-write contents when BYPASS=0).
//   All ports independent; any ports may share an address.
//  FSM states: IDLE, SWEEP, DONE.
//   IDLE : clr_req=1 -> SWEEP, idx <= 0. Write in same cycle as clr_req still performed.
//   SWEEP: each cycle mem[idx] <= 0, idx <= idx+1; clr_busy=1. When idx==DEPTH-1 -> DONE. Takes exactly DEPTH cycles.
//   DONE : clr_done=1 for one cycle, clr_busy=0 -> IDLE unconditionally (clr_req here ignored).
//  During SWEEP: we=1 -> write discarded, wr_drop pulses next cycle; enabled reads return 0 (bypass disabled).
//  clr_req while SWEEP/DONE ignored, not queued.
//  idx is AW bits; terminates on DEPTH-1 compare, never wraps to re-clear entry 0.
//  Reset mid-sweep: array fully zeroed, FSM to IDLE, no clr_done pulse.
//  No X propagation: every register has a reset value; unused address bits do not exist (DEPTH = 2**AW exactly).
// TESTING
//  1. Reset, write wa=5 wd=0xDEADBEEF, next cycle ra0=5 re0=1 -> rd0=0xDEADBEEF one cycle later.
//  2. BYPASS=1: we=1 wa=7 wd=0x1234 with ra1=7 re1=1 same cycle -> rd1=0x1234 next edge; BYPASS=0 -> rd1=old value 0.
//  3. ZERO_R0=1: write wa=0 wd=0xFFFFFFFF, read ra0=0 -> rd0=0, wr_drop stays 0.
//  4. Fill entries 1..31 with index value, pulse clr_req -> clr_busy high 32 cycles, clr_done single pulse, then all reads 0.
//  5. we=1 wa=3 wd=0xAA mid-sweep -> wr_drop pulse, mem[3] reads 0 after done; clr_req mid-sweep -> no extra sweep.
//  6. Assert rst at sweep idx=10 -> clr_busy drops immediately, clr_done never pulses, all entries read 0, writes accepted next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised NRD-read / 1-write register file with clear sequencer
module regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    input  logic [NRD-1:0]    re,
    output logic [NRD*DW-1:0] rd,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic              we,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;

    // Writes land only in IDLE; entry 0 is read-only when hardwired to zero.
    assign wr_en = we && (state == IDLE) && !((ZERO_R0 != 0) && (wa == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            wr_drop  <= we && (state == SWEEP);
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= SWEEP;
                        idx      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Stop on the last entry rather than letting idx wrap back to 0.
                    if (idx == {AW{1'b1}}) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == SWEEP) begin
            mem[idx] <= '0;
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (re[p]) begin
                    if ((ZERO_R0 != 0) && (ra[p*AW +: AW] == '0)) begin
                        rd[p*DW +: DW] <= '0;
                    end else if (state == SWEEP) begin
                        rd[p*DW +: DW] <= '0;
                    end else if ((BYPASS != 0) && we && (state == IDLE) && (wa == ra[p*AW +: AW])) begin
                        rd[p*DW +: DW] <= wd;
                    end else begin
                        rd[p*DW +: DW] <= mem[ra[p*AW +: AW]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [1:0]  re;
    logic [63:0] rd, rd_nb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we, clr_req;
    logic        clr_busy, clr_done, wr_drop;
    logic        clr_busy_nb, clr_done_nb, wr_drop_nb;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .rd(rd),
        .wa(wa), .wd(wd), .we(we), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .rd(rd_nb),
        .wa(wa), .wd(wd), .we(we), .clr_req(clr_req),
        .clr_busy(clr_busy_nb), .clr_done(clr_done_nb), .wr_drop(wr_drop_nb)
    );

    typedef struct packed {
        logic        nb;
        logic        port;
        logic [31:0] val;
        logic [63:0] tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input logic [63:0] tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input logic nb, input logic port, input logic [31:0] val, input logic [63:0] tag);
        exp_t e;
        e.nb   = nb;
        e.port = port;
        e.val  = val;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = e.nb ? rd_nb[int'(e.port)*32 +: 32] : rd[int'(e.port)*32 +: 32];
            check(e.tag, obs, e.val);
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        rst = 1'b1; ra = '0; re = '0; wa = '0; wd = '0; we = 1'b0; clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", rd[31:0] | rd[63:32], 32'h0);
        check("rst_bsy", {31'h0, clr_busy}, 32'h0);
        check("rst_don", {31'h0, clr_done}, 32'h0);
        check("rst_drp", {31'h0, wr_drop}, 32'h0);
        rst = 1'b0;

        // Plain write then read one cycle later
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        we = 1'b0; ra[4:0] = 5'd5; re = 2'b01;
        expect_rd(1'b0, 1'b0, 32'hDEADBEEF, "wr_rd");
        expect_rd(1'b1, 1'b0, 32'hDEADBEEF, "wr_rd_nb");
        step();

        // Same-cycle write/read: bypass vs pre-write contents
        we = 1'b1; wa = 5'd7; wd = 32'h1234; ra[9:5] = 5'd7; re = 2'b10;
        expect_rd(1'b0, 1'b1, 32'h1234, "bypass");
        expect_rd(1'b1, 1'b1, 32'h0, "nobyp");
        step();
        we = 1'b0; re = 2'b00;
        expect_rd(1'b0, 1'b1, 32'h1234, "hold");
        expect_rd(1'b0, 1'b0, 32'hDEADBEEF, "hold0");
        step();
        re = 2'b10;
        expect_rd(1'b1, 1'b1, 32'h1234, "nb_late");
        step();

        // Hardwired zero entry
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = '0; re = 2'b01;
        expect_rd(1'b0, 1'b0, 32'h0, "r0_byp");
        step();
        we = 1'b0;
        check("r0_drop", {31'h0, wr_drop}, 32'h0);
        expect_rd(1'b0, 1'b0, 32'h0, "r0_rd");
        step();
        check("r0_drp2", {31'h0, wr_drop}, 32'h0);

        // Fill 1..31 with index, then full clear
        re = 2'b00;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i);
            step();
        end
        we = 1'b0;
        ra = {5'd1, 5'd31}; re = 2'b11;
        expect_rd(1'b0, 1'b0, 32'd31, "fill31");
        expect_rd(1'b0, 1'b1, 32'd1, "fill1");
        step();
        re = 2'b00; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (!clr_busy && !clr_done && done_cnt > 0) break;
            step();
        end
        check("busy_cyc", 32'(busy_cnt), 32'd32);
        check("done_cnt", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)}; re = 2'b11;
            expect_rd(1'b0, 1'b0, 32'h0, "clr_rd0");
            expect_rd(1'b0, 1'b1, 32'h0, "clr_rd1");
            step();
        end

        // Write and clr_req during sweep
        re = 2'b00; we = 1'b1; wa = 5'd3; wd = 32'h55;
        step();
        we = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        we = 1'b1; wa = 5'd3; wd = 32'hAA; ra[4:0] = 5'd3; re = 2'b01; clr_req = 1'b1;
        expect_rd(1'b0, 1'b0, 32'h0, "swp_rd");
        step();
        we = 1'b0; re = 2'b00; clr_req = 1'b0;
        check("drop_pls", {31'h0, wr_drop}, 32'h1);
        step();
        check("drop_clr", {31'h0, wr_drop}, 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 64 && done_cnt == 0; k++) begin
            if (clr_done) done_cnt++;
            else step();
        end
        check("sw_done", 32'(done_cnt), 32'd1);
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        check("no_resw", 32'(busy_cnt + done_cnt), 32'd0);
        ra[4:0] = 5'd3; re = 2'b01;
        expect_rd(1'b0, 1'b0, 32'h0, "m3_zero");
        step();

        // Reset in the middle of a sweep
        re = 2'b00; we = 1'b1; wa = 5'd9; wd = 32'h99;
        step();
        wa = 5'd20; wd = 32'h2020;
        step();
        we = 1'b0; ra = {5'd20, 5'd9}; re = 2'b11;
        expect_rd(1'b0, 1'b0, 32'h99, "pre9");
        expect_rd(1'b0, 1'b1, 32'h2020, "pre20");
        step();
        re = 2'b00; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        check("mid_bsy", {31'h0, clr_busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_bsy2", {31'h0, clr_busy}, 32'h0);
        check("rst_rd2", rd[31:0] | rd[63:32], 32'h0);
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (clr_done) done_cnt++;
        end
        check("no_done", 32'(done_cnt), 32'd0);
        re = 2'b11;
        expect_rd(1'b0, 1'b0, 32'h0, "rst9");
        expect_rd(1'b0, 1'b1, 32'h0, "rst20");
        step();
        re = 2'b00; we = 1'b1; wa = 5'd9; wd = 32'h77;
        step();
        we = 1'b0; ra[4:0] = 5'd9; re = 2'b01;
        expect_rd(1'b0, 1'b0, 32'h77, "post_wr");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
